// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
// Line states are encoded as {d_plus, d_minus}.
package usb_tx_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_STUFF_LEN    = 6;
  localparam int DEF_BURST_LEN    = 64;
  localparam int DEF_EOP_SE0_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] nrzi_line(input logic level_j);
    return level_j ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last clock of each bit time.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_burst_serializer.sv
// USB transmit datapath: one-entry holding buffer, LSB-first shifter,
// bit stuffing, NRZI line coding, EOP generation and burst byte counting.
//
// state   | meaning
// IDLE    | line at J, waiting for a held byte
// SHIFT   | driving data bits through NRZI
// STUFF   | driving an inserted 0 after STUFF_LEN ones
// EOP_SE0 | SE0 for EOP_SE0_BITS bit times
// EOP_J   | one bit time of J closing the packet
module usb_burst_serializer
  import usb_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STUFF_LEN    = DEF_STUFF_LEN,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_valid,
  input  logic                         tx_last,
  output logic                         tx_ready,
  output logic                         d_plus,
  output logic                         d_minus,
  output logic                         busy,
  output logic [$clog2(BURST_LEN)-1:0] byte_count,
  output logic                         burst_done,
  output logic                         underrun
);

  localparam int BC_W   = $clog2(BURST_LEN);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int EOP_W  = $clog2(EOP_SE0_BITS + 1);

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [ONES_W-1:0] ONES_TRIG = ONES_W'(STUFF_LEN - 1);
  localparam logic [EOP_W-1:0]  EOP_LAST  = EOP_W'(EOP_SE0_BITS - 1);

  state_t              state, state_nxt;
  logic                tick;
  logic                hold_full, hold_last, last_reg, byte_end;
  logic [DATA_W-1:0]   hold_data, shreg;
  logic [IDX_W-1:0]    bit_idx;
  logic [ONES_W-1:0]   ones;
  logic [EOP_W-1:0]    eop_cnt;
  logic                level_j, level_nxt;
  logic [1:0]          line_nxt;
  logic                cur_bit, stuff_hit, last_bit, eop_last;
  logic                decide_now, load_now, byte_done, handshake;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (busy),
    .tick (tick)
  );

  assign cur_bit   = shreg[0];
  assign stuff_hit = cur_bit && (ones == ONES_TRIG);
  assign last_bit  = (bit_idx == IDX_LAST);
  assign eop_last  = (eop_cnt == EOP_LAST);
  assign byte_done = (state == SHIFT) && tick && last_bit;
  assign handshake = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A finished byte (or the stuff bit that trails it) reloads when a byte
  // is held and the packet is not over; otherwise the packet ends.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full) state_nxt = SHIFT;
      SHIFT:   if (tick) begin
                 if (stuff_hit)     state_nxt = STUFF;
                 else if (last_bit) state_nxt = (!last_reg && hold_full) ? SHIFT : EOP_SE0;
               end
      STUFF:   if (tick) begin
                 if (!byte_end) state_nxt = SHIFT;
                 else           state_nxt = (!last_reg && hold_full) ? SHIFT : EOP_SE0;
               end
      EOP_SE0: if (tick && eop_last) state_nxt = EOP_J;
      EOP_J:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    decide_now = tick && (((state == SHIFT) && !stuff_hit && last_bit) ||
                          ((state == STUFF) && byte_end));
    load_now   = hold_full && ((state == IDLE) || (decide_now && !last_reg));
    tx_ready   = !hold_full || load_now;
    level_nxt  = level_j;
    line_nxt   = {d_plus, d_minus};
    if (load_now) begin
      level_nxt = hold_data[0] ? level_j : !level_j;
      line_nxt  = nrzi_line(level_nxt);
    end else if (decide_now) begin
      line_nxt = LINE_SE0;
    end else if (tick) begin
      case (state)
        SHIFT: begin
          level_nxt = (stuff_hit || !shreg[1]) ? !level_j : level_j;
          line_nxt  = nrzi_line(level_nxt);
        end
        STUFF: begin
          level_nxt = cur_bit ? level_j : !level_j;
          line_nxt  = nrzi_line(level_nxt);
        end
        EOP_SE0: if (eop_last) line_nxt = LINE_J;
        EOP_J: begin
          level_nxt = 1'b1;
          line_nxt  = LINE_J;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      shreg      <= '0;
      last_reg   <= 1'b0;
      bit_idx    <= '0;
      byte_end   <= 1'b0;
      ones       <= '0;
      eop_cnt    <= '0;
      level_j    <= 1'b1;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      byte_count <= '0;
      burst_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      {d_plus, d_minus} <= line_nxt;
      level_j    <= level_nxt;
      burst_done <= byte_done && (byte_count == BC_LAST);
      underrun   <= decide_now && !last_reg && !hold_full;

      if (handshake) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end

      if (byte_done) byte_count <= (byte_count == BC_LAST) ? '0 : byte_count + 1'b1;

      // A stuff bit after the final data bit defers the end-of-byte decision.
      if (load_now) begin
        shreg    <= hold_data;
        last_reg <= hold_last;
        bit_idx  <= '0;
        byte_end <= 1'b0;
      end else if ((state == SHIFT) && tick) begin
        if (last_bit) begin
          byte_end <= stuff_hit;
        end else begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end else if ((state == STUFF) && tick) begin
        byte_end <= 1'b0;
      end

      if ((state == SHIFT) && tick)
        ones <= (cur_bit && !stuff_hit) ? ones + 1'b1 : '0;
      else if (((state == STUFF) || (state == EOP_J)) && tick)
        ones <= '0;

      if ((state == EOP_SE0) && tick) eop_cnt <= eop_last ? '0 : eop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_burst_serializer.sv
// Self-checking bench for usb_burst_serializer: per-cycle line waveform is
// compared with a bit-level packet model (stuffing, NRZI, EOP).
module tb_usb_burst_serializer;

  localparam int CPB  = 8;
  localparam int DW   = 8;
  localparam int SL   = 6;
  localparam int BL   = 64;
  localparam int SE0B = 2;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_last, tx_ready;
  logic          d_plus, d_minus, busy;
  logic [5:0]    byte_count;
  logic          burst_done, underrun;

  usb_burst_serializer #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STUFF_LEN(SL),
    .BURST_LEN(BL), .EOP_SE0_BITS(SE0B)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .d_plus(d_plus), .d_minus(d_minus),
    .busy(busy), .byte_count(byte_count), .burst_done(burst_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  int bd_seen = 0, ur_seen = 0;
  int exp_bd = 0, exp_ur = 0, exp_bc = 0;
  int first_busy, ready_low_cnt;

  logic [DW-1:0] tx_bytes[$];
  logic [1:0]    exp_syms[$];
  logic [1:0]    got_lines[$];
  int            hs_cyc[$];

  always @(negedge clk) begin
    if (burst_done === 1'b1) bd_seen++;
    if (underrun === 1'b1) ur_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Packet model: LSB-first bits, a 0 after every SL consecutive ones,
  // NRZI from J (0 toggles), then SE0 x SE0B and one J.
  task automatic model_packet();
    logic lvl_j;
    int   ones;
    logic [DW-1:0] v;
    lvl_j = 1'b1;
    ones  = 0;
    exp_syms.delete();
    foreach (tx_bytes[i]) begin
      v = tx_bytes[i];
      for (int k = 0; k < DW; k++) begin
        if (!v[k]) lvl_j = !lvl_j;
        exp_syms.push_back(lvl_j ? J : K);
        ones = v[k] ? ones + 1 : 0;
        if (ones == SL) begin
          lvl_j = !lvl_j;
          exp_syms.push_back(lvl_j ? J : K);
          ones = 0;
        end
      end
    end
    repeat (SE0B) exp_syms.push_back(SE0);
    exp_syms.push_back(J);
  endtask

  task automatic drive_bytes(input bit with_last);
    int n;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      tx_data  = tx_bytes[i];
      tx_valid = 1'b1;
      tx_last  = with_last && (i == tx_bytes.size() - 1);
      n = 0;
      while (!tx_ready && n < 5000) begin
        @(negedge clk);
        n++;
        ready_low_cnt++;
      end
      if (!tx_ready) chk("drv_timeout", 0, 1);
      hs_cyc.push_back(cyc);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic capture();
    int n;
    got_lines.delete();
    first_busy = -1;
    n = 0;
    while (!busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      chk("cap_start_timeout", 0, 1);
    end else begin
      first_busy = cyc;
      n = 0;
      while (busy && n < 40000) begin
        got_lines.push_back({d_plus, d_minus});
        @(negedge clk);
        n++;
      end
      if (busy) chk("cap_end_timeout", 0, 1);
    end
  endtask

  task automatic run_packet(input string tag, input bit with_last);
    int mism;
    model_packet();
    exp_bd += (exp_bc + tx_bytes.size()) / BL;
    exp_bc  = (exp_bc + tx_bytes.size()) % BL;
    if (!with_last) exp_ur++;
    hs_cyc.delete();
    fork
      drive_bytes(with_last);
      capture();
    join
    chk({tag, "_len"}, got_lines.size(), exp_syms.size() * CPB);
    mism = 0;
    for (int i = 0; i < got_lines.size() && i < exp_syms.size() * CPB; i++)
      if (got_lines[i] !== exp_syms[i / CPB]) mism++;
    chk({tag, "_wave_mism"}, mism, 0);
    if (hs_cyc.size() > 0) chk({tag, "_latency"}, first_busy - hs_cyc[0], 2);
    @(negedge clk);
    chk({tag, "_byte_count"}, byte_count, exp_bc);
    chk({tag, "_idle_line"}, {d_plus, d_minus}, J);
  endtask

  initial begin
    int bd0, ur0, bad, n;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
    ready_low_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_line", {d_plus, d_minus}, J);
    chk("rst_busy", busy, 0);
    chk("rst_bc", byte_count, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);

    tx_bytes = '{8'h80};
    run_packet("b80", 1'b1);

    tx_bytes = '{8'hFF, 8'h00};
    run_packet("ff00", 1'b1);
    chk("ff00_bit_times", got_lines.size(), (17 + SE0B + 1) * CPB);

    // Five trailing ones must not combine with the next packet's first 1.
    tx_bytes = '{8'hF8};
    run_packet("ones_a", 1'b1);
    tx_bytes = '{8'h01};
    run_packet("ones_b", 1'b1);

    ur0 = ur_seen;
    tx_bytes = '{8'h5A};
    run_packet("underrun", 1'b0);
    chk("underrun_pulse", ur_seen - ur0, 1);
    tx_bytes = '{8'hC3};
    run_packet("late_byte", 1'b1);

    ready_low_cnt = 0;
    tx_bytes = '{8'h3C, 8'h3C, 8'h81};
    run_packet("hold", 1'b1);
    chk("hold_hs2_gap", hs_cyc[1] - hs_cyc[0], 1);
    chk("hold_hs3_gap", hs_cyc[2] - hs_cyc[1], DW * CPB);
    chk("hold_ready_low", ready_low_cnt, DW * CPB - 1);

    for (int p = 0; p < 5; p++) begin
      tx_bytes.delete();
      repeat ($urandom_range(1, 4)) tx_bytes.push_back(8'($urandom_range(0, 255)));
      run_packet("rnd", 1'b1);
    end

    tx_bytes = '{8'h00, 8'h00, 8'h00};
    fork
      drive_bytes(1'b0);
      begin
        n = 0;
        while (!busy && n < 400) begin
          @(negedge clk);
          n++;
        end
        repeat (2 * DW * CPB + 32) @(negedge clk);
      end
    join
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_line", {d_plus, d_minus}, J);
    chk("midrst_busy", busy, 0);
    chk("midrst_bc", byte_count, 0);
    chk("midrst_ready", tx_ready, 1);
    rst = 1'b0;
    exp_bc = 0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || {d_plus, d_minus} != J) bad++;
    end
    chk("midrst_no_eop", bad, 0);

    bd0 = bd_seen;
    ur0 = ur_seen;
    tx_bytes.delete();
    repeat (BL) tx_bytes.push_back(8'($urandom_range(0, 255)));
    run_packet("burst", 1'b1);
    chk("burst_pulse", bd_seen - bd0, 1);
    chk("burst_no_underrun", ur_seen - ur0, 0);

    repeat (4) @(negedge clk);
    chk("total_burst_done", bd_seen, exp_bd);
    chk("total_underrun", ur_seen, exp_ur);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
